// File: rtl/pps_align_ctrl.sv
// pps_align_ctrl: phase-alignment controller for the local 1PPS divider.
// Measures the signed cycle offset between each GPS 1PPS rising edge and the
// matching local 1PPS rising edge, tracks lock, pulses DIV_RESET when the
// phase error stays too large, and enters holdover when GPS goes missing.
//
// Ports:
//   CLK_SYS      system clock
//   CLK_RST      asynchronous active-low reset
//   _1PPS_GPS    GPS 1PPS (asynchronous, synchronised here)
//   _1PPS_Local  divider 1PPS (delayed by an equal-depth chain)
//   DIV_RESET    one-cycle registered pulse restarting the divider
//   PHASE_ERR    signed offset in cycles, positive = local lags GPS
//   PHASE_VALID  one-cycle strobe when PHASE_ERR updates
//   LOCKED       alignment locked
//   HOLDOVER     GPS missing, local running free
//   RESYNC_CNT   saturating count of DIV_RESET pulses
//
// Optional feature: define PPS_ALIGN_RESYNC_CNT_EN to build the resync counter;
// otherwise RESYNC_CNT is tied to 0.
module pps_align_ctrl #(
   parameter int unsigned MAX_MEAS    = 1000,
   parameter int unsigned ERR_THRESH  = 4,
   parameter int unsigned BAD_COUNT   = 3,
   parameter int unsigned LOCK_COUNT  = 8,
   parameter int unsigned GPS_TIMEOUT = 15_000_000,
   parameter int unsigned ERR_W       = 16
) (
   input  logic                    CLK_SYS,
   input  logic                    CLK_RST,
   input  logic                    _1PPS_GPS,
   input  logic                    _1PPS_Local,
   output logic                    DIV_RESET,
   output logic signed [ERR_W-1:0] PHASE_ERR,
   output logic                    PHASE_VALID,
   output logic                    LOCKED,
   output logic                    HOLDOVER,
   output logic [7:0]              RESYNC_CNT
);

   localparam int unsigned MEAS_W  = $clog2(MAX_MEAS + 1);
   localparam int unsigned GOOD_W  = $clog2(LOCK_COUNT + 1);
   localparam int unsigned BAD_W   = $clog2(BAD_COUNT + 1);
   localparam int unsigned ERR_MAX = 2 ** (ERR_W - 1) - 1;
   localparam logic [23:0] WD_MAX  = 24'(GPS_TIMEOUT);

   typedef enum logic [2:0] {StIdle, StArmed, StGpsFirst, StLocFirst, StEval} state_e;

   state_e                  state_q, state_d;
   logic [2:0]              gps_sync_q, loc_sync_q;
   logic [MEAS_W-1:0]       meas_cnt_q, meas_cnt_d;
   logic signed [ERR_W-1:0] err_q, err_d;
   logic                    timeout_q, timeout_d;
   logic [GOOD_W-1:0]       good_cnt_q, good_cnt_d;
   logic [BAD_W-1:0]        bad_cnt_q, bad_cnt_d;
   logic [23:0]             wd_cnt_q, wd_cnt_d;
   logic                    div_reset_q, div_reset_d;
   logic signed [ERR_W-1:0] phase_err_q, phase_err_d;
   logic                    phase_valid_q, phase_valid_d;
   logic                    locked_q, locked_d;
   logic                    holdover_q, holdover_d;

   logic                    gps_edge, loc_edge, wd_expired, meas_good;
   logic [31:0]             err_mag;
   logic signed [ERR_W-1:0] err_pos, err_neg;
   logic [ERR_W-1:0]        err_abs;

   // Both chains are three deep so GPS and local edges see identical latency.
   assign gps_edge = gps_sync_q[1] & ~gps_sync_q[2];
   assign loc_edge = loc_sync_q[1] & ~loc_sync_q[2];

   // Holding off the force on a GPS edge lets that edge be processed normally.
   assign wd_expired = (wd_cnt_q == WD_MAX) && !gps_edge;

   // Pair distance is meas_cnt+1, clamped so negation cannot overflow.
   always_comb begin
      err_mag = 32'(meas_cnt_q) + 32'd1;
      if (err_mag > 32'(ERR_MAX)) begin
         err_mag = 32'(ERR_MAX);
      end
      err_pos = ERR_W'(err_mag);
      err_neg = -err_pos;
      err_abs = err_q[ERR_W-1] ? ERR_W'(-err_q) : err_q;
      meas_good = !timeout_q && (32'(err_abs) <= ERR_THRESH);
   end

   always_comb begin
      state_d       = state_q;
      meas_cnt_d    = meas_cnt_q;
      err_d         = err_q;
      timeout_d     = timeout_q;
      good_cnt_d    = good_cnt_q;
      bad_cnt_d     = bad_cnt_q;
      div_reset_d   = 1'b0;
      phase_err_d   = phase_err_q;
      phase_valid_d = 1'b0;
      locked_d      = locked_q;
      holdover_d    = holdover_q;
      wd_cnt_d      = wd_cnt_q;

      if (gps_edge) begin
         wd_cnt_d = '0;
      end else if (wd_cnt_q != WD_MAX) begin
         wd_cnt_d = wd_cnt_q + 24'd1;
      end

      unique case (state_q)
         StIdle: begin
            if (gps_edge) begin
               state_d    = StGpsFirst;
               meas_cnt_d = '0;
            end
         end
         StArmed: begin
            if (gps_edge && loc_edge) begin
               err_d     = '0;
               timeout_d = 1'b0;
               state_d   = StEval;
            end else if (gps_edge) begin
               state_d    = StGpsFirst;
               meas_cnt_d = '0;
            end else if (loc_edge) begin
               state_d    = StLocFirst;
               meas_cnt_d = '0;
            end
         end
         StGpsFirst: begin
            if (loc_edge) begin
               err_d     = err_pos;
               timeout_d = 1'b0;
               state_d   = StEval;
            end else if (meas_cnt_q == MEAS_W'(MAX_MEAS - 1)) begin
               timeout_d = 1'b1;
               state_d   = StEval;
            end else begin
               meas_cnt_d = meas_cnt_q + MEAS_W'(1);
            end
         end
         StLocFirst: begin
            if (gps_edge) begin
               err_d     = err_neg;
               timeout_d = 1'b0;
               state_d   = StEval;
            end else if (meas_cnt_q == MEAS_W'(MAX_MEAS - 1)) begin
               timeout_d = 1'b1;
               state_d   = StEval;
            end else begin
               meas_cnt_d = meas_cnt_q + MEAS_W'(1);
            end
         end
         StEval: begin
            state_d = StArmed;
            if (!timeout_q) begin
               phase_err_d   = err_q;
               phase_valid_d = 1'b1;
            end
            if (meas_good) begin
               bad_cnt_d = '0;
               if (good_cnt_q != GOOD_W'(LOCK_COUNT)) begin
                  good_cnt_d = good_cnt_q + GOOD_W'(1);
               end
               if (good_cnt_d == GOOD_W'(LOCK_COUNT)) begin
                  locked_d = 1'b1;
               end
            end else if (!timeout_q) begin
               bad_cnt_d  = bad_cnt_q + BAD_W'(1);
               good_cnt_d = '0;
               locked_d   = 1'b0;
            end
            if (timeout_q || (bad_cnt_d == BAD_W'(BAD_COUNT))) begin
               div_reset_d = 1'b1;
               locked_d    = 1'b0;
               good_cnt_d  = '0;
               bad_cnt_d   = '0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Holdover lets the divider free-run: no resync, just park in ARMED.
      if (wd_expired) begin
         holdover_d  = 1'b1;
         locked_d    = 1'b0;
         div_reset_d = 1'b0;
         if (state_q != StIdle) begin
            state_d = StArmed;
         end
      end else if (gps_edge) begin
         holdover_d = 1'b0;
      end
   end

   always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
      if (!CLK_RST) begin
         state_q       <= StIdle;
         gps_sync_q    <= '0;
         loc_sync_q    <= '0;
         meas_cnt_q    <= '0;
         err_q         <= '0;
         timeout_q     <= 1'b0;
         good_cnt_q    <= '0;
         bad_cnt_q     <= '0;
         wd_cnt_q      <= '0;
         div_reset_q   <= 1'b0;
         phase_err_q   <= '0;
         phase_valid_q <= 1'b0;
         locked_q      <= 1'b0;
         holdover_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         gps_sync_q    <= {gps_sync_q[1:0], _1PPS_GPS};
         loc_sync_q    <= {loc_sync_q[1:0], _1PPS_Local};
         meas_cnt_q    <= meas_cnt_d;
         err_q         <= err_d;
         timeout_q     <= timeout_d;
         good_cnt_q    <= good_cnt_d;
         bad_cnt_q     <= bad_cnt_d;
         wd_cnt_q      <= wd_cnt_d;
         div_reset_q   <= div_reset_d;
         phase_err_q   <= phase_err_d;
         phase_valid_q <= phase_valid_d;
         locked_q      <= locked_d;
         holdover_q    <= holdover_d;
      end
   end

   assign DIV_RESET   = div_reset_q;
   assign PHASE_ERR   = phase_err_q;
   assign PHASE_VALID = phase_valid_q;
   assign LOCKED      = locked_q;
   assign HOLDOVER    = holdover_q;

`ifdef PPS_ALIGN_RESYNC_CNT_EN
   logic [7:0] resync_cnt_q, resync_cnt_d;

   always_comb begin
      resync_cnt_d = resync_cnt_q;
      if (div_reset_q && (resync_cnt_q != 8'hFF)) begin
         resync_cnt_d = resync_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
      if (!CLK_RST) begin
         resync_cnt_q <= '0;
      end else begin
         resync_cnt_q <= resync_cnt_d;
      end
   end

   assign RESYNC_CNT = resync_cnt_q;
`else
   assign RESYNC_CNT = '0;
`endif

endmodule

// File: doc/pps_align_ctrl.md
Name: pps_align_ctrl

Overview:
Phase-alignment controller for the local 1PPS divider. It measures the signed cycle offset between each GPS 1PPS rising edge and the matching local 1PPS rising edge, and reports lock status. When the phase error stays too large it pulses DIV_RESET so the divider re-arms on the next GPS pulse. It also detects GPS loss (holdover). It sits between the GPS input, the divider and the disciplining loop, which consumes PHASE_ERR/PHASE_VALID.

Parameters:
MAX_MEAS, 1000, max cycles between paired edges (100 us @10 MHz); beyond this the pair is a timeout
ERR_THRESH, 4, max |PHASE_ERR| counted as a good measurement
BAD_COUNT, 3, consecutive bad measurements that trigger a resync
LOCK_COUNT, 8, consecutive good measurements required to assert LOCKED
GPS_TIMEOUT, 15_000_000, cycles without a GPS edge before entering holdover
ERR_W, 16, PHASE_ERR width (signed)

Ports:
CLK_SYS  in  1  system clock (10 MHz)
CLK_RST  in  1  asynchronous active-low reset
_1PPS_GPS  in  1  GPS 1PPS, asynchronous to CLK_SYS
_1PPS_Local  in  1  divider output 1PPS
DIV_RESET  out  1  one-cycle pulse that restarts the divider
PHASE_ERR  out  ERR_W  signed offset in cycles; positive means local lags GPS
PHASE_VALID  out  1  one-cycle strobe when PHASE_ERR updates
LOCKED  out  1  alignment locked
HOLDOVER  out  1  GPS missing, local running free
RESYNC_CNT  out  8  resync counter (optional feature)

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, and all counters are 0.
- Inputs:
  - _1PPS_GPS passes through a 2-flop synchroniser plus an edge register.
  - _1PPS_Local passes through an equal-depth register chain, so both edges see the same latency.
  - A rising edge is a 0 to 1 transition of the last two stages.
- IDLE:
  - Local edges are ignored.
  - On a GPS edge, go to GPS_FIRST with meas_cnt=0.
- ARMED:
  - GPS edge only: go to GPS_FIRST, meas_cnt=0.
  - Local edge only: go to LOC_FIRST, meas_cnt=0.
  - Both in the same cycle: err=0, go to EVAL.
- GPS_FIRST: meas_cnt increments each cycle.
  - Local edge: err=+(meas_cnt+1), go to EVAL.
  - meas_cnt reaches MAX_MEAS: timeout, go to EVAL.
- LOC_FIRST: meas_cnt increments each cycle.
  - GPS edge: err=-(meas_cnt+1), go to EVAL.
  - meas_cnt reaches MAX_MEAS: timeout, go to EVAL.
- EVAL (one cycle):
  - PHASE_ERR<=err and PHASE_VALID=1. On a timeout, PHASE_VALID stays 0 and PHASE_ERR holds its previous value.
  - A measurement is good if |err|<=ERR_THRESH: good_cnt++ (saturating at LOCK_COUNT) and bad_cnt=0.
  - Otherwise it is bad: bad_cnt++, good_cnt=0, LOCKED<=0.
  - LOCKED<=1 when good_cnt reaches LOCK_COUNT.
  - A timeout or bad_cnt==BAD_COUNT triggers a resync: DIV_RESET=1 for exactly this one cycle; LOCKED, good_cnt and bad_cnt are cleared; next state is IDLE.
  - Otherwise the next state is ARMED.
- Err arithmetic: computed in ERR_W bits, saturating at +/-(2^(ERR_W-1)-1).
- GPS watchdog (free-running 24-bit counter):
  - Cleared on every GPS edge.
  - When it reaches GPS_TIMEOUT: HOLDOVER<=1, LOCKED<=0, FSM forced to ARMED from any state except IDLE. No DIV_RESET is issued, so the local 1PPS free-runs.
  - The counter saturates at GPS_TIMEOUT.
  - The next GPS edge clears HOLDOVER in the following cycle; that edge is processed normally.
- Reset mid-measurement: asynchronous return to the reset values, no DIV_RESET emitted.
- DIV_RESET is registered. There is never more than one pulse per measurement.

Optional Feature:
- Macro PPS_ALIGN_RESYNC_CNT_EN.
- When defined: RESYNC_CNT is an 8-bit counter incremented on every DIV_RESET pulse. It saturates at 255 and is cleared only by CLK_RST.
- When undefined: RESYNC_CNT is tied to 0 and no counter logic is synthesised.

Test Plan:
Use MAX_MEAS=100, ERR_THRESH=4, BAD_COUNT=2, LOCK_COUNT=3, GPS_TIMEOUT=2000 and a 1PPS period of 1000 cycles.
1. Local edge 3 cycles after each GPS edge -> PHASE_ERR=+3 with PHASE_VALID each second; LOCKED rises after the 3rd measurement; DIV_RESET never asserts.
2. Local edge 10 cycles before GPS, repeated -> PHASE_ERR=-10 twice; DIV_RESET pulses once for 1 cycle after the 2nd; FSM returns to IDLE; RESYNC_CNT=1 when the macro is defined.
3. Local pulse absent for 150 cycles after a GPS edge -> timeout at 100 cycles; immediate single DIV_RESET; PHASE_VALID not asserted.
4. GPS and local edges in the same cycle -> PHASE_ERR=0 and PHASE_VALID=1.
5. Locked, then GPS stops -> HOLDOVER=1 and LOCKED=0 at 2000 cycles after the last GPS edge, no DIV_RESET; GPS resumes -> HOLDOVER clears and measurement resumes.
6. CLK_RST asserted during GPS_FIRST -> all outputs 0 immediately; after release a local edge alone is ignored until a GPS edge arrives.
